// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver with a one-entry holding register and consumer handshake.
// The serial line is double-synchronized and sampled mid-bit from a per-bit counter.
module uart_rx_deser #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RX,
  output logic [7:0] UART_RX,
  output logic       UART_RX_valid,
  input  logic       UART_RX_ack,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t        r_state;
  logic          r_meta;
  logic          r_rxs;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_rx;
  logic          r_valid;
  logic          r_ferr;
  logic          r_ovr;

  logic w_half;
  logic w_full;

  always_comb begin
    w_half = (r_cnt == HALF_M1);
    w_full = (r_cnt == FULL_M1);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_meta  <= 1'b1;
      r_rxs   <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_rx    <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_meta <= RX;
      r_rxs  <= r_meta;
      r_ferr <= 1'b0;

      // Consumer release; a byte completing in the same cycle overrides this below.
      if (r_valid && UART_RX_ack)
        r_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (!r_rxs)
            r_state <= S_START;
        end

        S_START: begin
          if (w_half) begin
            r_cnt   <= '0;
            r_state <= r_rxs ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DATA: begin
          if (w_full) begin
            r_cnt   <= '0;
            r_shift <= {r_rxs, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7)
              r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_STOP: begin
          if (w_full) begin
            r_cnt <= '0;
            if (r_rxs) begin
              r_state <= S_IDLE;
              if (!r_valid || UART_RX_ack) begin
                r_rx    <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_ovr <= 1'b1;
              end
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_WAIT_HIGH: begin
          r_cnt <= '0;
          if (r_rxs)
            r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    UART_RX       = r_rx;
    UART_RX_valid = r_valid;
    FRAME_ERR     = r_ferr;
    OVERRUN       = r_ovr;
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser at 16 clocks per bit: a table of good frames
// plus hand-written sequences for glitch, framing error, handshake and reset cases.
module tb_uart_rx_deser;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;
  // Stop sample edge counted from the edge where the start bit is driven:
  // 2 synchronizer flops + IDLE detect cycle + half bit + 9 bits.
  localparam int SMP   = 3 + CPB / 2 + 9 * CPB;

  logic       CLK;
  logic       RESET;
  logic       RX;
  logic [7:0] UART_RX;
  logic       UART_RX_valid;
  logic       UART_RX_ack;
  logic       FRAME_ERR;
  logic       OVERRUN;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int fe0;

  logic       g_v154, g_v155, g_fe155, g_fe156;
  logic [7:0] g_rx155;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t tbl[12];

  uart_rx_deser #(.CLKS_PER_BIT(CPB)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .RX           (RX),
    .UART_RX      (UART_RX),
    .UART_RX_valid(UART_RX_valid),
    .UART_RX_ack  (UART_RX_ack),
    .FRAME_ERR    (FRAME_ERR),
    .OVERRUN      (OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (FRAME_ERR) fe_cnt++;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one full frame; ack_at selects a frame cycle at which to pulse ack (-1 = none).
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_at);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int k = 0; k < FRAME; k++) begin
      RX = fr[k / CPB];
      UART_RX_ack = (k == ack_at);
      if (k == SMP - 1) g_v154 = UART_RX_valid;
      if (k == SMP) begin
        g_v155  = UART_RX_valid;
        g_fe155 = FRAME_ERR;
        g_rx155 = UART_RX;
      end
      if (k == SMP + 1) g_fe156 = FRAME_ERR;
      tick();
    end
    UART_RX_ack = 1'b0;
  endtask

  task automatic do_ack;
    UART_RX_ack = 1'b1;
    tick();
    UART_RX_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{8'h73, 8'h73};
    tbl[1]  = '{8'h73, 8'h73};
    tbl[2]  = '{8'h00, 8'h00};
    tbl[3]  = '{8'h00, 8'h00};
    tbl[4]  = '{8'h00, 8'h00};
    tbl[5]  = '{8'h09, 8'h09};
    tbl[6]  = '{8'h00, 8'h00};
    tbl[7]  = '{8'h00, 8'h00};
    tbl[8]  = '{8'h00, 8'h00};
    tbl[9]  = '{8'h05, 8'h05};
    tbl[10] = '{8'hFF, 8'hFF};
    tbl[11] = '{8'h80, 8'h80};

    RESET = 1'b0;
    RX = 1'b1;
    UART_RX_ack = 1'b0;
    repeat (3) tick();
    chk("rst_rx", UART_RX, 8'h00);
    chk("rst_valid", UART_RX_valid, 1'b0);
    chk("rst_ferr", FRAME_ERR, 1'b0);
    chk("rst_ovr", OVERRUN, 1'b0);
    RESET = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 12; i++) begin
      send_frame(tbl[i].data, 1'b1, -1);
      chk("tbl_valid_before_stop", g_v154, 1'b0);
      chk("tbl_valid_after_stop", g_v155, 1'b1);
      chk("tbl_ferr", g_fe155, 1'b0);
      chk("tbl_rx_at_valid", g_rx155, tbl[i].exp_rx);
      chk("tbl_ovr", OVERRUN, 1'b0);
      repeat (2) tick();
      chk("tbl_valid_held", UART_RX_valid, 1'b1);
      do_ack();
      chk("tbl_valid_drop", UART_RX_valid, 1'b0);
      chk("tbl_rx_kept", UART_RX, tbl[i].exp_rx);
    end

    // Short low glitch must be rejected silently.
    fe0 = fe_cnt;
    RX = 1'b0;
    repeat (4) tick();
    RX = 1'b1;
    repeat (30) tick();
    chk("glitch_valid", UART_RX_valid, 1'b0);
    chk("glitch_ferr", fe_cnt - fe0, 0);
    chk("glitch_ovr", OVERRUN, 1'b0);
    send_frame(8'hA5, 1'b1, -1);
    chk("a5_valid", g_v155, 1'b1);
    chk("a5_rx", g_rx155, 8'hA5);
    do_ack();

    // Framing error, then line held low; only one pulse, no byte.
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, -1);
    chk("fe_pulse", g_fe155, 1'b1);
    chk("fe_pulse_end", g_fe156, 1'b0);
    chk("fe_valid", g_v155, 1'b0);
    RX = 1'b0;
    repeat (40) tick();
    RX = 1'b1;
    repeat (4) tick();
    chk("fe_count", fe_cnt - fe0, 1);
    chk("fe_valid_after", UART_RX_valid, 1'b0);
    send_frame(8'h12, 1'b1, -1);
    chk("12_valid", g_v155, 1'b1);
    chk("12_rx", g_rx155, 8'h12);
    do_ack();

    // Ack in the same cycle a byte completes: new byte loaded, no overrun.
    send_frame(8'h66, 1'b1, -1);
    chk("same_first", UART_RX, 8'h66);
    send_frame(8'h99, 1'b1, SMP - 1);
    chk("same_valid", g_v155, 1'b1);
    chk("same_rx", g_rx155, 8'h99);
    chk("same_ovr", OVERRUN, 1'b0);
    do_ack();
    chk("same_drop", UART_RX_valid, 1'b0);

    // Overrun: second byte dropped while the first is unconsumed.
    send_frame(8'h41, 1'b1, -1);
    chk("ovr_first", UART_RX, 8'h41);
    send_frame(8'h42, 1'b1, -1);
    chk("ovr_rx", UART_RX, 8'h41);
    chk("ovr_valid", UART_RX_valid, 1'b1);
    chk("ovr_flag", OVERRUN, 1'b1);
    do_ack();
    chk("ovr_drop", UART_RX_valid, 1'b0);
    chk("ovr_kept", UART_RX, 8'h41);
    repeat (20) tick();
    chk("ovr_sticky", OVERRUN, 1'b1);

    // Reset in the middle of 0xFF (data bit 4).
    RX = 1'b0;
    for (int k = 0; k < 4 * CPB + CPB; k++) begin
      RX = (k < CPB) ? 1'b0 : 1'b1;
      tick();
    end
    RESET = 1'b0;
    repeat (3) tick();
    chk("mid_rst_rx", UART_RX, 8'h00);
    chk("mid_rst_valid", UART_RX_valid, 1'b0);
    chk("mid_rst_ferr", FRAME_ERR, 1'b0);
    chk("mid_rst_ovr", OVERRUN, 1'b0);
    RESET = 1'b1;
    fe0 = fe_cnt;
    repeat (FRAME - 5 * CPB) tick();
    chk("mid_rst_no_byte", UART_RX_valid, 1'b0);
    chk("mid_rst_no_fe", fe_cnt - fe0, 0);
    send_frame(8'h3C, 1'b1, -1);
    chk("3c_valid", g_v155, 1'b1);
    chk("3c_rx", g_rx155, 8'h3C);
    chk("3c_ovr", OVERRUN, 1'b0);
    do_ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, gives CLK cycles per serial bit (100 MHz / 115200); legal range 4..65535.
REQ-002 CLK  input  1  system clock; all state on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 RX  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 UART_RX  output  8  received byte, stable while UART_RX_valid is high.
REQ-006 UART_RX_valid  output  1  holding register contains an unconsumed byte.
REQ-007 UART_RX_ack  input  1  consumer acknowledge; level-sampled.
REQ-008 FRAME_ERR  output  1  one-cycle pulse when a stop bit samples low.
REQ-009 OVERRUN  output  1  sticky flag: a completed byte was dropped because the holding register was full.

Function
REQ-010 RX SHALL pass through a 2-flop synchronizer whose flops reset to 1; all decoding SHALL use the synchronized value (rxs).
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH; reset state IDLE.
REQ-012 IDLE: a cycle with rxs=0 SHALL move to START and clear the bit counter (cycle t0).
REQ-013 START: at t0+CLKS_PER_BIT/2 (integer divide) rxs SHALL be resampled; 0 -> DATA, 1 -> IDLE (glitch rejected, no flag).
REQ-014 DATA: bit i (i=0..7) SHALL be sampled at t0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT into shift position i (LSB first); after bit 7 -> STOP.
REQ-015 STOP: sample at t0+CLKS_PER_BIT/2+9*CLKS_PER_BIT; rxs=1 -> byte complete, go IDLE; rxs=0 -> FRAME_ERR high the following cycle only, byte discarded, go WAIT_HIGH.
REQ-016 WAIT_HIGH SHALL remain until rxs=1, then go IDLE; no start is detected while in WAIT_HIGH.
REQ-017 On byte complete with UART_RX_valid=0, UART_RX SHALL load the byte and UART_RX_valid SHALL rise on the cycle after the stop sample.
REQ-018 On byte complete with UART_RX_valid=1 (and no ack in that cycle), the new byte SHALL be dropped, UART_RX unchanged, and OVERRUN set to 1.
REQ-019 OVERRUN SHALL clear only on reset.
REQ-020 While UART_RX_valid=1 and UART_RX_ack is sampled 1, UART_RX_valid SHALL go 0 on the next cycle; UART_RX keeps its last value.
REQ-021 If ack is sampled 1 in the same cycle a byte completes, the new byte SHALL be loaded and UART_RX_valid SHALL stay 1 (no overrun).
REQ-022 UART_RX_ack while UART_RX_valid=0 SHALL be ignored.
REQ-023 The bit-period counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and reload to 0 at every sample point, with no wrap between samples.
REQ-024 Receiving SHALL continue independently of the handshake state.

Reset
REQ-025 While RESET=0: state IDLE, UART_RX=0x00, UART_RX_valid=0, FRAME_ERR=0, OVERRUN=0, synchronizer=1, counters=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; after release a partial frame still on RX SHALL be decoded only from the next falling edge seen in IDLE.

Verification (CLKS_PER_BIT=16)
REQ-027 Send 0x73 ('s') with a valid stop bit -> UART_RX=0x73, UART_RX_valid rises exactly 1 cycle after the stop sample, FRAME_ERR=0, OVERRUN=0.
REQ-028 Send 9 bytes 0x73,00,00,00,09,00,00,00,05; ack each 3 cycles after valid -> consumer reads exactly that sequence, valid drops 1 cycle after each ack, OVERRUN=0.
REQ-029 Send 0x41 then 0x42 without acking; ack after the second -> UART_RX=0x41 delivered, OVERRUN=1, 0x42 never appears.
REQ-030 Send 0x55 with stop bit forced 0 -> one-cycle FRAME_ERR pulse, UART_RX_valid stays 0; hold RX low 40 cycles, release, send 0x12 -> 0x12 received.
REQ-031 Drive RX low for 4 cycles in IDLE -> FSM returns to IDLE, no valid, no flags; a following 0xA5 is received correctly.
REQ-032 Assert RESET at data bit 4 of 0xFF for 3 cycles -> all outputs at reset values; the next full frame 0x3C is received as 0x3C.
